// File: rtl/cci_mpf_prim_fifo_drain.sv
// Drains an MPF primitive FIFO into a registered valid/ready stream through a 2-entry output/skid buffer.
// Optional delivered-beat counter enabled by defining CCI_MPF_PRIM_FIFO_DRAIN_CNT_EN.

module cci_mpf_prim_fifo_drain_chk #(
  parameter int N_DATA_BITS = 32
) (
  input logic                   clk,
  input logic                   reset,
  input logic                   src_notEmpty,
  input logic                   src_deq_en,
  input logic                   out_valid,
  input logic                   out_ready,
  input logic [N_DATA_BITS-1:0] out_data
);

  deq_only_when_not_empty: assert property (
    @(posedge clk) disable iff (reset) src_deq_en |-> src_notEmpty
  ) else $fatal(1, "cci_mpf_prim_fifo_drain: dequeue issued while source is empty");

  hold_while_stalled: assert property (
    @(posedge clk) disable iff (reset)
      (out_valid && !out_ready) |=> (out_valid && $stable(out_data))
  ) else $fatal(1, "cci_mpf_prim_fifo_drain: output changed while stalled");

endmodule

module cci_mpf_prim_fifo_drain #(
  parameter int N_DATA_BITS = 32,
  parameter int N_CNT_BITS  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_DATA_BITS-1:0] src_first,
  input  logic                   src_notEmpty,
  output logic                   src_deq_en,
  output logic [N_DATA_BITS-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   notBusy,
  output logic [N_CNT_BITS-1:0]  beat_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [N_DATA_BITS-1:0] skid_data;
  logic                   xfer;
  logic                   load_out_src;
  logic                   load_out_skid;
  logic                   load_skid;

  assign xfer = out_valid && out_ready;

  // Dequeue depends only on registered occupancy, never on out_ready.
  assign src_deq_en = src_notEmpty && (state != TWO) && !reset;

  always_comb begin
    state_next    = state;
    load_out_src  = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state)
      EMPTY: begin
        if (src_deq_en) begin
          state_next   = ONE;
          load_out_src = 1'b1;
        end else begin
          state_next = EMPTY;
        end
      end
      ONE: begin
        if (src_deq_en && xfer) begin
          state_next   = ONE;
          load_out_src = 1'b1;
        end else if (src_deq_en) begin
          state_next = TWO;
          load_skid  = 1'b1;
        end else if (xfer) begin
          state_next = EMPTY;
        end else begin
          state_next = ONE;
        end
      end
      TWO: begin
        if (xfer) begin
          state_next    = ONE;
          load_out_skid = 1'b1;
        end else begin
          state_next = TWO;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      notBusy   <= 1'b1;
    end else begin
      state     <= state_next;
      out_valid <= (state_next != EMPTY);
      notBusy   <= (state_next == EMPTY);
    end
  end

  // Data registers carry no reset; validity is tracked by the control flops.
  always_ff @(posedge clk) begin
    if (load_out_src) begin
      out_data <= src_first;
    end else if (load_out_skid) begin
      out_data <= skid_data;
    end
    if (load_skid) begin
      skid_data <= src_first;
    end
  end

`ifdef CCI_MPF_PRIM_FIFO_DRAIN_CNT_EN
  localparam logic [N_CNT_BITS-1:0] CNT_ONE = N_CNT_BITS'(1);
  logic [N_CNT_BITS-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (xfer) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  assign beat_count = cnt;
`else
  assign beat_count = '0;
`endif

  cci_mpf_prim_fifo_drain_chk #(
    .N_DATA_BITS(N_DATA_BITS)
  ) u_chk (
    .clk         (clk),
    .reset       (reset),
    .src_notEmpty(src_notEmpty),
    .src_deq_en  (src_deq_en),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data)
  );

endmodule

// File: tb/tb_cci_mpf_prim_fifo_drain.sv
// Self-checking bench for cci_mpf_prim_fifo_drain: queue-based source/occupancy model,
// a vector table for the stall/skid sequence, and hand sequences for reset and counter wrap.
module tb_cci_mpf_prim_fifo_drain;

`ifdef CCI_MPF_PRIM_FIFO_DRAIN_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] src_first;
  logic        src_notEmpty;
  logic        src_deq_en;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        notBusy;
  logic [3:0]  beat_count;

  cci_mpf_prim_fifo_drain #(.N_DATA_BITS(32), .N_CNT_BITS(4)) dut (
    .clk(clk), .reset(reset), .src_first(src_first), .src_notEmpty(src_notEmpty),
    .src_deq_en(src_deq_en), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .notBusy(notBusy), .beat_count(beat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cnt_model = 0;
  int n_deq = 0;
  logic [31:0] src_q[$];
  logic [31:0] infl[$];
  logic [31:0] got[$];
  logic [31:0] sent[$];

  typedef struct {
    logic        rdy;
    logic        deq;
    logic        vld;
    logic [31:0] data;
    logic        nb;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_cnt();
    return CNT_ON ? 4'(cnt_model % 16) : 4'h0;
  endfunction

  task automatic drive_src();
    src_notEmpty = (src_q.size() > 0);
    src_first    = (src_q.size() > 0) ? src_q[0] : 32'h0;
  endtask

  // Expected outputs follow from how many entries have been pulled but not yet delivered.
  task automatic model_check();
    chk("deq_en", src_deq_en, src_notEmpty && (infl.size() < 2));
    chk("out_valid", out_valid, infl.size() > 0);
    chk("notBusy", notBusy, infl.size() == 0);
    if (infl.size() > 0) chk("out_data", out_data, infl[0]);
    chk("beat_count", beat_count, exp_cnt());
  endtask

  task automatic advance();
    logic deq, xfer;
    logic [31:0] d;
    deq  = src_deq_en;
    xfer = out_valid && out_ready;
    d    = out_data;
    @(posedge clk);
    #1;
    if (xfer) begin
      got.push_back(d);
      if (infl.size() > 0) void'(infl.pop_front());
      cnt_model++;
    end
    if (deq && src_q.size() > 0) infl.push_back(src_q.pop_front());
    if (deq) n_deq++;
    drive_src();
  endtask

  task automatic cycle();
    @(negedge clk);
    model_check();
    advance();
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b1};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 32'hA, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 32'hA, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 32'hA, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 32'hA, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 32'hB, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 32'hC, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b1};

    // Reset with a non-empty source: nothing may be dequeued.
    reset = 1'b1; out_ready = 1'b1; src_notEmpty = 1'b1; src_first = 32'h77;
    #12;
    chk("rst_deq_en", src_deq_en, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_notBusy", notBusy, 1'b1);
    chk("rst_beat_count", beat_count, 4'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    drive_src();

    // Idle source for 10 cycles.
    for (int i = 0; i < 10; i++) cycle();

    // Streaming 1..8 with out_ready held high.
    for (int i = 1; i <= 8; i++) src_q.push_back(32'(i));
    drive_src();
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      chk("seq8_deq", src_deq_en, i < 8);
      chk("seq8_valid", out_valid, (i >= 1) && (i <= 8));
      if ((i >= 1) && (i <= 8)) chk("seq8_data", out_data, 32'(i));
      model_check();
      advance();
    end
    chk("seq8_beat_count", beat_count, CNT_ON ? 4'h8 : 4'h0);

    // Stall with 0xA,0xB,0xC queued: output and skid fill, then drain in order.
    src_q = '{32'hA, 32'hB, 32'hC};
    drive_src();
    for (int i = 0; i < 8; i++) begin
      out_ready = tbl[i].rdy;
      @(negedge clk);
      chk("tbl_deq", src_deq_en, tbl[i].deq);
      chk("tbl_valid", out_valid, tbl[i].vld);
      chk("tbl_notBusy", notBusy, tbl[i].nb);
      if (tbl[i].vld) chk("tbl_data", out_data, tbl[i].data);
      model_check();
      advance();
    end

    // Fill both entries, then assert reset between clock edges.
    out_ready = 1'b0;
    src_q = '{32'h11, 32'h22, 32'h55};
    drive_src();
    for (int i = 0; i < 3; i++) cycle();
    @(negedge clk);
    chk("pre_rst_deq_en", src_deq_en, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_out_valid", out_valid, 1'b0);
    chk("async_notBusy", notBusy, 1'b1);
    chk("async_deq_en", src_deq_en, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    infl.delete();
    got.delete();
    cnt_model = 0;
    out_ready = 1'b1;
    drive_src();
    for (int i = 0; i < 4; i++) cycle();
    chk("after_rst_first", (got.size() > 0) ? got[0] : 32'hFFFF_FFFF, 32'h55);

    // Counter wrap: 16 more transfers bring the total since reset to 17.
    for (int i = 0; i < 16; i++) src_q.push_back(32'h100 + 32'(i));
    drive_src();
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (cnt_model == 15 && out_valid) chk("wrap_15", beat_count, CNT_ON ? 4'hF : 4'h0);
      if (cnt_model == 16 && out_valid) chk("wrap_16", beat_count, 4'h0);
      if (cnt_model == 17 && !out_valid) chk("wrap_17", beat_count, CNT_ON ? 4'h1 : 4'h0);
    end
    chk("wrap_total", cnt_model, 17);

    // Random source pushes and random out_ready: order preserved, no drop, no duplicate.
    begin
      int pushed = 0;
      int cyc = 0;
      logic [31:0] d;
      got.delete();
      sent.delete();
      while (got.size() < 200 && cyc < 4000) begin
        if (pushed < 200 && $urandom_range(0, 9) < 7) begin
          d = $urandom;
          src_q.push_back(d);
          sent.push_back(d);
          pushed++;
        end
        drive_src();
        out_ready = 1'($urandom_range(0, 1));
        cycle();
        cyc++;
      end
      chk("rand_delivered", got.size(), 200);
      for (int i = 0; i < got.size() && i < sent.size(); i++) chk("rand_order", got[i], sent[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cci_mpf_prim_fifo_drain.md
Name: cci_mpf_prim_fifo_drain

Overview:
Reader-side adapter for the MPF primitive FIFOs. It pulls entries from a FIFO's dequeue interface (first, notEmpty, deq_en) and presents them downstream as a registered valid/ready stream. A 2-entry output/skid buffer removes any combinational path from downstream ready to deq_en and sustains one beat per cycle. It sits between any cci_mpf_prim FIFO and a pipelined consumer.

Parameters:
N_DATA_BITS, 32, width of the FIFO entry and the output data.
N_CNT_BITS, 32, width of the delivered-beat counter. Used only with the optional feature.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
src_first  in  N_DATA_BITS  head entry of the source FIFO; valid while src_notEmpty=1
src_notEmpty  in  1  source FIFO holds at least one entry
src_deq_en  out  1  dequeue strobe to the source FIFO
out_data  out  N_DATA_BITS  registered output data
out_valid  out  1  out_data is valid
out_ready  in  1  consumer accepts out_data this cycle
notBusy  out  1  both internal entries are empty
beat_count  out  N_CNT_BITS  count of delivered beats (optional feature)

Behaviour:
- Interface: one clock, clk. reset is asynchronous and active-high. All state flops clear on the assertion of reset, independent of clk.
- Reset values: out_valid=0, src_deq_en=0, notBusy=1, beat_count=0. out_data and skid data are don't-care; the data registers have no reset.
- Internal storage: an output register (out_data, out_valid) and one skid register (skid_data, skid_valid).
- State encodes the occupancy: EMPTY (0 entries), ONE (output register full), TWO (output and skid full).
- src_deq_en = src_notEmpty && (state != TWO). It is purely a function of registered state and src_notEmpty and never depends on out_ready.
- A downstream transfer occurs when out_valid && out_ready.
- EMPTY:
  - deq → ONE; out_data <= src_first.
  - no deq → stay.
  - out_ready is ignored.
- ONE:
  - deq && xfer → ONE; out_data <= src_first.
  - deq && !xfer → TWO; skid_data <= src_first.
  - !deq && xfer → EMPTY.
  - neither → stay.
- TWO:
  - xfer → ONE; out_data <= skid_data.
  - !xfer → stay; src_deq_en=0.
- Order: entries leave in the order they were dequeued. The skid entry is always older than any newly dequeued entry.
- Latency: an entry dequeued in cycle N is on out_data with out_valid=1 in cycle N+1 when the buffer is empty or draining.
- Throughput: 1 beat/cycle sustained while src_notEmpty=1 and out_ready=1.
- Hold rule: while out_valid=1 and out_ready=0, out_data and out_valid are stable.
- notBusy = (state == EMPTY).
- Source constraint: the block never asserts src_deq_en while src_notEmpty=0. When the source is a FIFO1, the producer must not enqueue in a cycle where src_deq_en=1. That is the producer's obligation, not this block's.
- Reset mid-operation: buffered entries are discarded. out_valid drops asynchronously. No dequeue is issued during reset.
- Simulation assertions:
  - $fatal if src_deq_en=1 while src_notEmpty=0.
  - $fatal if out_data changes while out_valid=1 and out_ready=0.

Optional Feature:
CCI_MPF_PRIM_FIFO_DRAIN_CNT_EN.
- Defined:
  - beat_count increments by 1 on every downstream transfer.
  - It wraps modulo 2^N_CNT_BITS, from all-ones to 0.
  - It is cleared by reset.
- Undefined:
  - beat_count is tied to 0.
  - No counter flops are instantiated.

Test Plan:
- Reset released, src_notEmpty=0 for 10 cycles → src_deq_en=0, out_valid=0, notBusy=1 throughout.
- Source preloaded 0x1..0x8, out_ready=1 held → src_deq_en=1 for 8 consecutive cycles. out_data is 0x1..0x8 on consecutive cycles, first beat one cycle after the first deq. beat_count=8 (macro on).
- Source holds 0xA,0xB,0xC; out_ready=0 → exactly 2 dequeues occur (0xA to the output, 0xB to the skid), then src_deq_en=0. out_data stays 0xA. Raise out_ready → 0xA, 0xB, 0xC delivered in order.
- Random out_ready at 50%, 200 random entries → output sequence equals input sequence, with no drop and no duplicate. No assertion fires.
- State TWO, assert reset asynchronously mid-cycle → out_valid=0 immediately, notBusy=1. After release the next entry 0x55 is delivered first.
- Macro on, N_CNT_BITS=4, 17 transfers → beat_count reads 0xF after 15 transfers, wraps to 0x0 at 16, reads 0x1 at 17.
